// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer:
// default widths, one-hot op bit positions and FSM state encoding.
package muldiv_pkg;

  localparam int MD_XLEN  = 64;
  localparam int MD_CNT_W = 7;
  localparam int OP_W     = 8;

  localparam int OP_MUL    = 0;
  localparam int OP_MULH   = 1;
  localparam int OP_MULHU  = 2;
  localparam int OP_MULHSU = 3;
  localparam int OP_DIV    = 4;
  localparam int OP_DIVU   = 5;
  localparam int OP_REM    = 6;
  localparam int OP_REMU   = 7;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_FIX,
    MD_DONE
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One-step datapath: shift-add multiply or restoring shift-subtract divide on a
// shared 2*XLEN accumulator {high, low}.
module muldiv_iter #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   opb_q;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     partial;
  logic [XLEN:0]     diff;

  // Multiply: low half starts as the multiplier and drains out to the right.
  // Divide: high half is the partial remainder, low half shifts dividend out
  // and quotient bits in.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    acc_next = acc;
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
    partial  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = partial - {1'b0, opb_q};
    if (is_div) begin
      if (partial >= {1'b0, opb_q}) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                          acc_next = {partial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc[XLEN-1:1]};
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (load) begin
      acc   <= {{XLEN{1'b0}}, op_a};
      opb_q <= op_b;
    end else if (step) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle sequencer for RV64 M-extension ops: accepts one op, iterates the
// shared datapath, fixes up signs and returns the result with its rd tag.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic [4:0]      dst_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      dst_o
);

  md_state_e         state, state_next;
  logic [CNT_W-1:0]  count;
  logic [OP_W-1:0]   op_q;
  logic              neg1_q, neg2_q;
  logic [4:0]        dst_q;

  logic              sgn1, sgn2, neg1, neg2;
  logic              is_div, is_rem, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]   abs1, abs2, iter_a, iter_b, special_res;
  logic [XLEN-1:0]   quo, rem, fix_res;
  logic [2*XLEN-1:0] acc, prod;

  always_comb begin
    sgn1     = op_i[OP_MUL] | op_i[OP_MULH] | op_i[OP_MULHSU] | op_i[OP_DIV] | op_i[OP_REM];
    sgn2     = op_i[OP_MUL] | op_i[OP_MULH] | op_i[OP_DIV] | op_i[OP_REM];
    neg1     = sgn1 & src1_i[XLEN-1];
    neg2     = sgn2 & src2_i[XLEN-1];
    abs1     = neg1 ? -src1_i : src1_i;
    abs2     = neg2 ? -src2_i : src2_i;
    is_div   = |op_i[OP_REMU:OP_DIV];
    is_rem   = op_i[OP_REM] | op_i[OP_REMU];
    div_zero = is_div && (src2_i == '0);
    div_ovf  = (op_i[OP_DIV] | op_i[OP_REM]) &&
               (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&src2_i);
    special  = div_zero | div_ovf;
    // RISC-V defines these results without trapping, so they bypass the datapath.
    if (div_zero) special_res = is_rem ? src1_i : '1;
    else          special_res = is_rem ? '0 : src1_i;
    iter_a   = is_div ? abs1 : abs2;
    iter_b   = is_div ? abs2 : abs1;
    accept   = ready_o & start_i & (|op_i) & ~flush_i;
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk_i),
    .load   (accept),
    .step   (state == MD_BUSY),
    .is_div (|op_q[OP_REMU:OP_DIV]),
    .op_a   (iter_a),
    .op_b   (iter_b),
    .acc    (acc)
  );

  always_comb begin
    prod    = (neg1_q ^ neg2_q) ? -acc : acc;
    quo     = (neg1_q ^ neg2_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem     = neg1_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_res = '0;
    if (op_q[OP_MUL])                      fix_res = prod[XLEN-1:0];
    else if (|op_q[OP_MULHSU:OP_MULH])     fix_res = prod[2*XLEN-1:XLEN];
    else if (|op_q[OP_DIVU:OP_DIV])        fix_res = quo;
    else if (|op_q[OP_REMU:OP_REM])        fix_res = rem;
  end

  always_comb begin
    state_next = state;
    ready_o    = (state == MD_IDLE);
    busy_o     = (state == MD_BUSY) || (state == MD_FIX);
    valid_o    = (state == MD_DONE);
    case (state)
      MD_IDLE: if (accept) state_next = special ? MD_DONE : MD_BUSY;
      MD_BUSY: if (count == CNT_W'(XLEN-1)) state_next = MD_FIX;
      MD_FIX:  state_next = MD_DONE;
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (flush_i) state_next = MD_IDLE;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst_i) begin
      state    <= MD_IDLE;
      count    <= '0;
      result_o <= '0;
      dst_o    <= '0;
    end else begin
      state <= state_next;
      if (accept)                count <= '0;
      else if (state == MD_BUSY) count <= count + 1'b1;
      if (accept && special) begin
        result_o <= special_res;
        dst_o    <= dst_i;
      end else if (state == MD_FIX && !flush_i) begin
        result_o <= fix_res;
        dst_o    <= dst_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q   <= op_i;
      neg1_q <= neg1;
      neg2_q <= neg2;
      dst_q  <= dst_i;
    end
  end

  op_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    (start_i && ready_o) |-> $onehot0(op_i));

endmodule
